// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers issued ops until both operands
// are known, snoops the CDB for wakeups, and dispatches one ready op per cycle to EX.
`timescale 1ns/1ps

module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int TYPE_W  = 6
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic              rdy_in,
  input  logic              clear_in,

  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [TYPE_W-1:0] issue_type,
  input  logic [31:0]       issue_vj,
  input  logic [31:0]       issue_vk,
  input  logic              issue_qj_valid,
  input  logic              issue_qk_valid,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [31:0]       issue_a,
  input  logic [31:0]       issue_pc,
  input  logic [TAG_W-1:0]  issue_dest,

  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_value,

  output logic              ex_valid,
  output logic [TYPE_W-1:0] ex_type,
  output logic [31:0]       ex_vj,
  output logic [31:0]       ex_vk,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_pc,
  output logic [TAG_W-1:0]  ex_dest
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [TYPE_W-1:0] op_type;
    logic [31:0]       vj;
    logic [31:0]       vk;
    logic              qj_valid;
    logic [TAG_W-1:0]  qj;
    logic              qk_valid;
    logic [TAG_W-1:0]  qk;
    logic [31:0]       a;
    logic [31:0]       pc;
    logic [TAG_W-1:0]  dest;
  } entry_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] ready;

  logic              ex_valid_q, ex_valid_d;
  logic [TYPE_W-1:0] ex_type_q,  ex_type_d;
  logic [31:0]       ex_vj_q,    ex_vj_d;
  logic [31:0]       ex_vk_q,    ex_vk_d;
  logic [31:0]       ex_a_q,     ex_a_d;
  logic [31:0]       ex_pc_q,    ex_pc_d;
  logic [TAG_W-1:0]  ex_dest_q,  ex_dest_d;

  logic             free_found, disp_found, accept;
  logic [IDX_W-1:0] free_idx, disp_idx;
  logic             hit_j, hit_k;
  entry_t           new_ent;

  // Priority pickers: scanning downwards leaves the lowest matching index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] && !ent_q[i].qj_valid && !ent_q[i].qk_valid;
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = free_found;
  assign accept      = issue_valid && issue_ready && rdy_in && !clear_in;

  // Incoming op with same-cycle CDB bypass on each pending operand.
  always_comb begin
    hit_j            = issue_qj_valid && cdb_valid && (issue_qj == cdb_tag);
    hit_k            = issue_qk_valid && cdb_valid && (issue_qk == cdb_tag);
    new_ent.op_type  = issue_type;
    new_ent.vj       = hit_j ? cdb_value : issue_vj;
    new_ent.vk       = hit_k ? cdb_value : issue_vk;
    new_ent.qj_valid = issue_qj_valid && !hit_j;
    new_ent.qj       = issue_qj;
    new_ent.qk_valid = issue_qk_valid && !hit_k;
    new_ent.qk       = issue_qk;
    new_ent.a        = issue_a;
    new_ent.pc       = issue_pc;
    new_ent.dest     = issue_dest;
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the if-chain infers a latch.
    busy_d     = busy_q;
    ent_d      = ent_q;
    ex_valid_d = ex_valid_q;
    ex_type_d  = ex_type_q;
    ex_vj_d    = ex_vj_q;
    ex_vk_d    = ex_vk_q;
    ex_a_d     = ex_a_q;
    ex_pc_d    = ex_pc_q;
    ex_dest_d  = ex_dest_q;

    if (clear_in) begin
      busy_d     = '0;
      ex_valid_d = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && cdb_valid) begin
          if (ent_q[i].qj_valid && ent_q[i].qj == cdb_tag) begin
            ent_d[i].vj       = cdb_value;
            ent_d[i].qj_valid = 1'b0;
          end
          if (ent_q[i].qk_valid && ent_q[i].qk == cdb_tag) begin
            ent_d[i].vk       = cdb_value;
            ent_d[i].qk_valid = 1'b0;
          end
        end
      end

      ex_valid_d = disp_found;
      if (disp_found) begin
        busy_d[disp_idx] = 1'b0;
        ex_type_d        = ent_q[disp_idx].op_type;
        ex_vj_d          = ent_q[disp_idx].vj;
        ex_vk_d          = ent_q[disp_idx].vk;
        ex_a_d           = ent_q[disp_idx].a;
        ex_pc_d          = ent_q[disp_idx].pc;
        ex_dest_d        = ent_q[disp_idx].dest;
      end

      // The free slot is never the dispatching one, since that one is busy.
      if (accept) begin
        busy_d[free_idx] = 1'b1;
        ent_d[free_idx]  = new_ent;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_type_q  <= '0;
      ex_vj_q    <= '0;
      ex_vk_q    <= '0;
      ex_a_q     <= '0;
      ex_pc_q    <= '0;
      ex_dest_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      ex_type_q  <= ex_type_d;
      ex_vj_q    <= ex_vj_d;
      ex_vk_q    <= ex_vk_d;
      ex_a_q     <= ex_a_d;
      ex_pc_q    <= ex_pc_d;
      ex_dest_q  <= ex_dest_d;
    end
  end

  // NOTE: entry payload is deliberately not reset; it is only ever read while its busy bit is set.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

  assign ex_valid = ex_valid_q;
  assign ex_type  = ex_type_q;
  assign ex_vj    = ex_vj_q;
  assign ex_vk    = ex_vk_q;
  assign ex_a     = ex_a_q;
  assign ex_pc    = ex_pc_q;
  assign ex_dest  = ex_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural reservation-station model.
`timescale 1ns/1ps

module tb_alu_rs;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;

  logic        clk_in = 1'b0;
  logic        rstn_in = 1'b0;
  logic        rdy_in, clear_in;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_type;
  logic [31:0] issue_vj, issue_vk, issue_a, issue_pc;
  logic        issue_qj_valid, issue_qk_valid;
  logic [3:0]  issue_qj, issue_qk, issue_dest;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        ex_valid;
  logic [5:0]  ex_type;
  logic [31:0] ex_vj, ex_vk, ex_a, ex_pc;
  logic [3:0]  ex_dest;

  int checks = 0;
  int failures = 0;

  alu_rs #(.RS_SIZE(8), .TAG_W(4), .TYPE_W(6)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_a(issue_a), .issue_pc(issue_pc),
    .issue_dest(issue_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .ex_valid(ex_valid), .ex_type(ex_type), .ex_vj(ex_vj), .ex_vk(ex_vk),
    .ex_a(ex_a), .ex_pc(ex_pc), .ex_dest(ex_dest)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: the station is a set of eight slots holding whole ops.
  typedef struct {
    bit          busy;
    logic [5:0]  t;
    logic [31:0] vj, vk, a, pc;
    bit          qjv, qkv;
    logic [3:0]  qj, qk, dest;
  } op_t;

  op_t         m_rs [8];
  logic        m_exv;
  logic [5:0]  m_ext;
  logic [31:0] m_exvj, m_exvk, m_exa, m_expc;
  logic [3:0]  m_exd;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear_in = 1'b0; issue_valid = 1'b0;
    issue_type = '0; issue_vj = '0; issue_vk = '0; issue_a = '0; issue_pc = '0;
    issue_qj_valid = 1'b0; issue_qk_valid = 1'b0; issue_qj = '0; issue_qk = '0; issue_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic offer(input logic [5:0] t, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjv, input logic [3:0] qj, input logic [3:0] dest);
    issue_valid = 1'b1; issue_type = t; issue_vj = vj; issue_vk = vk;
    issue_qj_valid = qjv; issue_qj = qj; issue_qk_valid = 1'b0; issue_qk = '0;
    issue_dest = dest; issue_a = 32'h100 + 32'(dest); issue_pc = 32'h4000 + 32'(dest) * 4;
  endtask

  task automatic broadcast(input logic [3:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
  endtask

  task automatic test_reset();
    idle();
    rstn_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checks++; if ({ex_valid, ex_type, ex_vj, ex_vk, ex_a, ex_pc, ex_dest} !== '0) begin failures++; $display("FAIL reset_outputs got valid=%0b type=%0h vj=%0h dest=%0h required all zero", ex_valid, ex_type, ex_vj, ex_dest); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%0b required=1", issue_ready); end
    rstn_in = 1'b1;
  endtask

  task automatic test_basic();
    offer(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 4'd3);
    tick(); idle();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL basic_edge1_valid got=%0b required=0", ex_valid); end
    tick();
    checks++; if ({ex_valid, ex_type, ex_vj, ex_vk, ex_dest} !== {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3}) begin failures++; $display("FAIL basic_dispatch got v=%0b t=%0d vj=%0d vk=%0d d=%0d required 1/1/5/7/3", ex_valid, ex_type, ex_vj, ex_vk, ex_dest); end
    checks++; if ({ex_a, ex_pc} !== {32'h103, 32'h400c}) begin failures++; $display("FAIL basic_a_pc got a=%0h pc=%0h required 103/400c", ex_a, ex_pc); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL basic_edge3_valid got=%0b required=0", ex_valid); end
  endtask

  task automatic test_cdb_wakeup();
    offer(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd2, 4'd5);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL wakeup_early_dispatch cycle=%0d got=%0b required=0", i, ex_valid); end
    end
    broadcast(4'd2, 32'd10);
    tick(); idle();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL wakeup_edge1 got=%0b required=0", ex_valid); end
    tick();
    checks++; if ({ex_valid, ex_type, ex_vj, ex_vk, ex_dest} !== {1'b1, OP_SUB, 32'd10, 32'd1, 4'd5}) begin failures++; $display("FAIL wakeup_dispatch got v=%0b t=%0d vj=%0d vk=%0d d=%0d required 1/2/10/1/5", ex_valid, ex_type, ex_vj, ex_vk, ex_dest); end
    tick();
  endtask

  task automatic test_issue_bypass();
    offer(OP_ADD, 32'd0, 32'd3, 1'b1, 4'd4, 4'd1);
    broadcast(4'd4, 32'hDEAD);
    tick(); idle();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL bypass_edge1 got=%0b required=0", ex_valid); end
    tick();
    checks++; if ({ex_valid, ex_vj, ex_vk} !== {1'b1, 32'hDEAD, 32'd3}) begin failures++; $display("FAIL bypass_dispatch got v=%0b vj=%0h vk=%0h required 1/dead/3", ex_valid, ex_vj, ex_vk); end
    tick();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      offer(OP_ADD, 32'd0, 32'(k), 1'b1, 4'd9, 4'(k));
      tick();
    end
    checks++; if ({issue_ready, ex_valid} !== 2'b00) begin failures++; $display("FAIL fill_full got ready=%0b valid=%0b required 0/0", issue_ready, ex_valid); end
    offer(OP_ADD, 32'd1234, 32'd1, 1'b0, 4'd0, 4'd15);
    tick(); idle();
    checks++; if ({issue_ready, ex_valid} !== 2'b00) begin failures++; $display("FAIL fill_ninth got ready=%0b valid=%0b required 0/0", issue_ready, ex_valid); end
    broadcast(4'd9, 32'd99);
    tick(); idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if ({ex_valid, ex_dest, ex_vj, ex_vk} !== {1'b1, 4'(k), 32'd99, 32'(k)}) begin failures++; $display("FAIL fill_order k=%0d got v=%0b d=%0d vj=%0d vk=%0d required 1/%0d/99/%0d", k, ex_valid, ex_dest, ex_vj, ex_vk, k, k); end
      if (k == 0) begin
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_after_first got=%0b required=1", issue_ready); end
      end
    end
    tick();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL fill_ninth_leak got=%0b required=0", ex_valid); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 3; k++) begin
      offer(OP_SUB, 32'd0, 32'd2, 1'b1, 4'd5, 4'(k));
      tick();
    end
    offer(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 4'd14);
    clear_in = 1'b1;
    tick(); idle();
    checks++; if ({ex_valid, issue_ready} !== 2'b01) begin failures++; $display("FAIL clear_state got valid=%0b ready=%0b required 0/1", ex_valid, issue_ready); end
    broadcast(4'd5, 32'd77);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL clear_flushed_dispatch cycle=%0d got=%0b required=0", i, ex_valid); end
    end
    for (int k = 0; k < 8; k++) begin
      offer(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd6, 4'(k));
      tick();
      if (k == 6) begin
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL clear_free_slots after 7 got=%0b required=1", issue_ready); end
      end
    end
    idle();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL clear_refill_full got=%0b required=0", issue_ready); end
    clear_in = 1'b1;
    tick(); idle();
  endtask

  task automatic test_stall_and_async_reset();
    offer(OP_ADD, 32'd11, 32'd22, 1'b0, 4'd0, 4'd6);
    tick();
    offer(OP_SUB, 32'd33, 32'd44, 1'b0, 4'd0, 4'd7);
    tick();
    checks++; if ({ex_valid, ex_vj, ex_dest} !== {1'b1, 32'd11, 4'd6}) begin failures++; $display("FAIL stall_pre got v=%0b vj=%0d d=%0d required 1/11/6", ex_valid, ex_vj, ex_dest); end
    offer(OP_ADD, 32'd55, 32'd0, 1'b0, 4'd0, 4'd8);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({ex_valid, ex_type, ex_vj, ex_vk, ex_dest, issue_ready} !== {1'b1, OP_ADD, 32'd11, 32'd22, 4'd6, 1'b1}) begin failures++; $display("FAIL stall_hold cycle=%0d got v=%0b t=%0d vj=%0d vk=%0d d=%0d required 1/1/11/22/6", i, ex_valid, ex_type, ex_vj, ex_vk, ex_dest); end
    end
    idle();
    tick();
    checks++; if ({ex_valid, ex_type, ex_vj, ex_dest} !== {1'b1, OP_SUB, 32'd33, 4'd7}) begin failures++; $display("FAIL stall_resume got v=%0b t=%0d vj=%0d d=%0d required 1/2/33/7", ex_valid, ex_type, ex_vj, ex_dest); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL stall_accepted_offer got=%0b required=0", ex_valid); end
    offer(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd3, 4'd9);
    tick(); idle();
    offer(OP_ADD, 32'd66, 32'd77, 1'b0, 4'd0, 4'd10);
    tick(); idle();
    #2 rstn_in = 1'b0;
    #1;
    checks++; if ({ex_valid, ex_type, ex_vj, ex_vk, ex_a, ex_pc, ex_dest} !== '0) begin failures++; $display("FAIL async_reset_outputs got v=%0b vj=%0h d=%0h required all zero", ex_valid, ex_vj, ex_dest); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%0b required=1", issue_ready); end
    #2 rstn_in = 1'b1;
  endtask

  task automatic model_step();
    op_t nxt [8];
    op_t n;
    int  r, f;
    if (clear_in) begin
      foreach (m_rs[i]) m_rs[i].busy = 1'b0;
      m_exv = 1'b0;
      return;
    end
    if (!rdy_in) return;
    nxt = m_rs;
    r = -1;
    f = -1;
    for (int i = 7; i >= 0; i--) begin
      if (m_rs[i].busy && !m_rs[i].qjv && !m_rs[i].qkv) r = i;
      if (!m_rs[i].busy) f = i;
    end
    if (cdb_valid) begin
      foreach (nxt[i]) begin
        if (nxt[i].busy && nxt[i].qjv && nxt[i].qj == cdb_tag) begin nxt[i].vj = cdb_value; nxt[i].qjv = 1'b0; end
        if (nxt[i].busy && nxt[i].qkv && nxt[i].qk == cdb_tag) begin nxt[i].vk = cdb_value; nxt[i].qkv = 1'b0; end
      end
    end
    m_exv = (r >= 0);
    if (r >= 0) begin
      nxt[r].busy = 1'b0;
      m_ext = m_rs[r].t; m_exvj = m_rs[r].vj; m_exvk = m_rs[r].vk;
      m_exa = m_rs[r].a; m_expc = m_rs[r].pc; m_exd = m_rs[r].dest;
    end
    if (issue_valid && f >= 0) begin
      n.busy = 1'b1; n.t = issue_type; n.a = issue_a; n.pc = issue_pc; n.dest = issue_dest;
      n.qj = issue_qj; n.qk = issue_qk;
      n.qjv = issue_qj_valid && !(cdb_valid && issue_qj == cdb_tag);
      n.qkv = issue_qk_valid && !(cdb_valid && issue_qk == cdb_tag);
      n.vj = (issue_qj_valid && !n.qjv) ? cdb_value : issue_vj;
      n.vk = (issue_qk_valid && !n.qkv) ? cdb_value : issue_vk;
      nxt[f] = n;
    end
    m_rs = nxt;
  endtask

  task automatic test_random();
    bit exp_ready;
    idle();
    rstn_in = 1'b0;
    tick();
    rstn_in = 1'b1;
    foreach (m_rs[i]) m_rs[i].busy = 1'b0;
    m_exv = 1'b0; m_ext = '0; m_exvj = '0; m_exvk = '0; m_exa = '0; m_expc = '0; m_exd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rdy_in         = ($urandom_range(0, 9) != 0);
      clear_in       = ($urandom_range(0, 39) == 0);
      issue_valid    = ($urandom_range(0, 9) < 6);
      issue_type     = 6'($urandom);
      issue_vj       = $urandom;
      issue_vk       = $urandom;
      issue_a        = $urandom;
      issue_pc       = $urandom;
      issue_qj_valid = $urandom_range(0, 1) == 1;
      issue_qk_valid = $urandom_range(0, 2) == 0;
      issue_qj       = 4'($urandom_range(0, 7));
      issue_qk       = 4'($urandom_range(0, 7));
      issue_dest     = 4'($urandom);
      cdb_valid      = rdy_in && ($urandom_range(0, 9) < 5);
      cdb_tag        = 4'($urandom_range(0, 7));
      cdb_value      = $urandom;
      model_step();
      tick();
      exp_ready = 1'b0;
      foreach (m_rs[i]) if (!m_rs[i].busy) exp_ready = 1'b1;
      checks++; if ({ex_valid, ex_type, ex_vj, ex_vk, ex_a, ex_pc, ex_dest} !== {m_exv, m_ext, m_exvj, m_exvk, m_exa, m_expc, m_exd}) begin failures++; $display("FAIL random_ex cycle=%0d got v=%0b t=%0h vj=%0h vk=%0h a=%0h pc=%0h d=%0h required v=%0b t=%0h vj=%0h vk=%0h a=%0h pc=%0h d=%0h", cyc, ex_valid, ex_type, ex_vj, ex_vk, ex_a, ex_pc, ex_dest, m_exv, m_ext, m_exvj, m_exvk, m_exa, m_expc, m_exd); end
      checks++; if (issue_ready !== exp_ready) begin failures++; $display("FAIL random_issue_ready cycle=%0d got=%0b required=%0b", cyc, issue_ready, exp_ready); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_issue_bypass();
    test_fill();
    test_clear();
    test_stall_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU in the out-of-order core. It sits between the issue stage and the combinational EX unit. It buffers decoded ALU/branch/jump operations until both source operands are available, capturing operands from the common data bus (CDB) as they are broadcast. Each cycle it dispatches at most one ready operation, through registered outputs, to EX; the external CDB arbiter broadcasts the EX result.

## Interface
Parameters:
- RS_SIZE, 8, number of entries (power of two)
- TAG_W, 4, ROB index width
- TYPE_W, 6, operation-type code width (matches the EX `ordertype` encoding)

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rstn_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low freezes all state and outputs
- clear_in  in  1  mispredict flush, synchronous
- issue_valid  in  1  new op offered
- issue_ready  out  1  free entry exists
- issue_type  in  TYPE_W  op type
- issue_vj / issue_vk  in  32  operand values
- issue_qj_valid / issue_qk_valid  in  1  operand still pending (1 = wait on tag)
- issue_qj / issue_qk  in  TAG_W  producer ROB tags
- issue_a  in  32  immediate
- issue_pc  in  32  instruction pc
- issue_dest  in  TAG_W  destination ROB tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  producing ROB tag
- cdb_value  in  32  broadcast value
- ex_valid  out  1  dispatch valid (registered)
- ex_type  out  TYPE_W  to EX `ordertype`
- ex_vj / ex_vk / ex_a / ex_pc  out  32  to EX operand inputs
- ex_dest  out  TAG_W  ROB tag travelling with the result

## Operation
- Entry fields: busy, type, vj, vk, qj_valid, qj, qk_valid, qk, a, pc, dest.
- Accept: when issue_valid && issue_ready && rdy_in && !clear_in, write the lowest-index non-busy entry and set busy=1.
- Issue bypass: if cdb_valid, an incoming qX_valid is set, and qX == cdb_tag in the same cycle, store vX = cdb_value with qX_valid = 0.
- Wakeup: for every busy entry with qj_valid && qj == cdb_tag && cdb_valid, set vj = cdb_value and qj_valid = 0. Apply the same rule to qk. Both operands may wake in the same cycle.
- Ready: busy && !qj_valid && !qk_valid, evaluated on the registered state. An entry woken this cycle becomes dispatchable next cycle.
- Dispatch: select the lowest-index ready entry. On the next edge, load its fields into the ex_* registers, set ex_valid = 1, and clear the entry's busy bit. With no ready entry, ex_valid = 0 and the other ex_* outputs hold their previous values.
- The freed slot is not reusable in the same cycle. issue_ready = !(all entries busy), computed from registered busy bits only.
- issue_valid while issue_ready = 0: the offer is ignored and no state changes.
- clear_in: all busy bits cleared and ex_valid = 0 on the next edge. Issue and dispatch in that cycle are discarded. clear_in has priority over rdy_in = 0.
- rdy_in = 0 (without clear_in): no accept, no wakeup, no dispatch, and all registers hold. Upstream guarantees the CDB is also stalled.
- Reset (rstn_in low, any time): all busy = 0, ex_valid = 0, ex_type = 0, ex_vj/vk/a/pc = 0, ex_dest = 0. issue_ready = 1 after reset.

## Timing
- Latency from accepting an op with both operands ready to ex_valid: 2 edges. Edge 1 writes the entry; edge 2 dispatches it.
- Latency from the CDB broadcast that satisfies the last pending operand to ex_valid: 2 edges.
- Throughput: 1 dispatch per cycle.
- Accept and dispatch of different entries can occur on the same edge.
- issue_ready is a function of registered state only, with no combinational path from issue_valid.
- ex_* drive EX directly, so EX inputs are always register outputs.

## Test plan
- Reset, then issue ADD with vj=5, vk=7, both q invalid, dest=3. Require: entry 0 busy after edge 1; after edge 2, ex_valid=1, ex_type=ADD, ex_vj=5, ex_vk=7, ex_dest=3; after edge 3, ex_valid=0.
- Issue SUB with qj_valid=1, qj=2, vk=1, then cdb_valid with tag 2, value 10 two cycles later. Require: no dispatch before the broadcast; ex_valid=1 with ex_vj=10 on the second edge after the broadcast.
- Issue with qj=4 pending while cdb_valid, tag 4, value 0xDEAD arrives in the same cycle. Require: the stored vj is 0xDEAD and the op dispatches on the next edge.
- Fill all 8 entries with ops pending on tag 9. Require: issue_ready=0, and a ninth issue_valid is ignored. Broadcast tag 9. Require: 8 consecutive ex_valid cycles dispatching in index order 0..7, with issue_ready=1 after the first dispatch.
- Fill 3 entries, then assert clear_in for one cycle. Require: ex_valid=0, all entries free, and no later dispatch of the flushed ops.
- Hold rdy_in=0 for 3 cycles while a ready entry exists. Require: no dispatch and outputs unchanged. Then pull rstn_in low mid-operation. Require: all outputs zero immediately without waiting for a clock edge, and issue_ready=1.
